// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the round-robin mux sequencer.
// Channel-to-select mapping is kept here so every user agrees on the wiring.
package mux_seq_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    OFFER
  } state_t;

  // Returns {sel_0, sel_1, sel_2, sel_3} for a channel index; the final
  // stage is steered by the upper index bits and the first stage by the lower.
  function automatic logic [SEL_W-1:0] chan_to_sel(input logic [SEL_W-1:0] chan);
    return {chan[1], chan[0], chan[3], chan[2]};
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotate the request vector so the search
// begins just after last_grant, take the lowest set bit, then undo the rotation.
module rr_priority_picker
  import mux_seq_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_grant,
  output logic             found,
  output logic [SEL_W-1:0] winner
);

  logic [SEL_W-1:0] start;
  logic [N_REQ-1:0] rotated;
  logic [SEL_W-1:0] offset;

  assign start = last_grant + 4'd1;

  always_comb begin
    rotated = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rotated[i] = req[SEL_W'(i) + start];
    end
  end

  // Descending scan so the lowest rotated position, i.e. the nearest
  // requester after last_grant, is the one left in offset.
  always_comb begin
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = SEL_W'(i);
      end
    end
  end

  assign found  = |req;
  assign winner = offset + start;

endmodule

// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer that owns the 16:1 mux selects, waits a settle time,
// captures the mux output and offers it downstream on a valid/ready handshake.
module mux_rr_sequencer
  import mux_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             mux_in,
  input  logic             sample_ready,
  output logic             sel_0,
  output logic             sel_1,
  output logic             sel_2,
  output logic             sel_3,
  output logic [N_REQ-1:0] grant,
  output logic             sample_valid,
  output logic             sample_data,
  output logic [SEL_W-1:0] sample_chan,
  output logic             busy
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [7:0]       count;
  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] sel_bus;
  logic             found;
  logic [SEL_W-1:0] winner;
  logic             start_txn;
  logic             capture;
  logic             handshake;

  rr_priority_picker u_picker (
    .req        (req),
    .last_grant (last_grant),
    .found      (found),
    .winner     (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start_txn  = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          start_txn  = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (count == '0) begin
          capture    = 1'b1;
          next_state = OFFER;
        end
      end
      OFFER: begin
        if (sample_ready) begin
          handshake  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Selects and sample_chan only move when a new transaction starts, so the
  // mux stays settled through HOLD and OFFER and beyond the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant       <= '0;
      sel_bus     <= '0;
      sample_chan <= '0;
      sample_data <= 1'b0;
      count       <= '0;
      last_grant  <= 4'hF;
    end else begin
      if (start_txn) begin
        grant       <= N_REQ'(1) << winner;
        sel_bus     <= chan_to_sel(winner);
        sample_chan <= winner;
        count       <= HOLD_LOAD;
      end else if (state == HOLD && count != '0) begin
        count <= count - 8'd1;
      end
      if (capture) begin
        sample_data <= mux_in;
      end
      if (handshake) begin
        last_grant <= sample_chan;
        grant      <= '0;
      end
    end
  end

  assign {sel_0, sel_1, sel_2, sel_3} = sel_bus;
  assign sample_valid = (state == OFFER);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Self-checking bench for mux_rr_sequencer: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, random soak.
module tb_mux_rr_sequencer;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req = '0;
  logic        sample_ready = 1'b0;
  logic [15:0] din = '0;
  logic        mux_in;
  logic        sel_0, sel_1, sel_2, sel_3;
  logic [15:0] grant;
  logic        sample_valid;
  logic        sample_data;
  logic [3:0]  sample_chan;
  logic        busy;

  int total = 0;
  int passed = 0;
  bit started = 0;

  always #5 clk = ~clk;

  // Physical mux: final stage on {sel_2, sel_3}, first stage on {sel_0, sel_1}.
  assign mux_in = din[{sel_2, sel_3, sel_0, sel_1}];

  mux_rr_sequencer #(.HOLD_CYCLES(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .mux_in       (mux_in),
    .sample_ready (sample_ready),
    .sel_0        (sel_0),
    .sel_1        (sel_1),
    .sel_2        (sel_2),
    .sel_3        (sel_3),
    .grant        (grant),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_chan  (sample_chan),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: m_age counts cycles since the grant; ages 1..H are the
  // settle window and age H+1 is the offer of the captured sample.
  bit         m_active;
  int         m_age;
  logic [3:0] m_chan;
  logic [3:0] m_last;
  logic       m_data;

  always @(posedge clk or posedge reset) begin
    int  c;
    bit  got;
    if (reset) begin
      m_active = 0;
      m_age    = 0;
      m_chan   = 0;
      m_last   = 4'd15;
      m_data   = 0;
    end else if (!m_active) begin
      if (req != 0) begin
        got = 0;
        for (int d = 1; d <= 16 && !got; d++) begin
          c = (int'(m_last) + d) % 16;
          if (req[c]) begin
            got    = 1;
            m_chan = 4'(c);
          end
        end
        m_active = 1;
        m_age    = 1;
      end
    end else if (m_age <= H) begin
      if (m_age == H) m_data = din[m_chan];
      m_age++;
    end else if (sample_ready) begin
      m_active = 0;
      m_last   = m_chan;
    end
  end

  always @(negedge clk) begin
    logic [15:0] exp_grant;
    logic        exp_valid;
    if (started) begin
      exp_grant = m_active ? (16'd1 << m_chan) : 16'd0;
      exp_valid = m_active && (m_age == H + 1);
      check("cycle_outputs",
            {5'd0, busy, sample_valid, sample_data, sample_chan,
             sel_2, sel_3, sel_0, sel_1, grant},
            {5'd0, m_active, exp_valid, m_data, m_chan, m_chan, exp_grant});
    end
  end

  function automatic logic [31:0] all_outputs();
    return {8'd0, busy, sample_valid, sample_data, sample_chan,
            sel_0, sel_1, sel_2, sel_3, grant};
  endfunction

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (!sample_valid && cycles < 40);
    if (!sample_valid) check("valid_timeout", 32'(sample_valid), 32'd1);
  endtask

  task automatic drain();
    req = '0;
    sample_ready = 1'b1;
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic applyStimulus();
    int          cyc;
    logic [31:0] snap;
    logic [15:0] dval;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    started = 1;
    check("reset_state", all_outputs(), 32'd0);
    reset = 1'b0;

    // Single requester 0; dropping req during HOLD must not abort
    din = 16'h0001;
    sample_ready = 1'b1;
    req = 16'h0001;
    @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    check("b_busy", 32'(busy), 32'd1);
    check("b_sel", 32'({sel_0, sel_1, sel_2, sel_3}), 32'd0);
    wait_valid(cyc);
    check("b_latency", 32'(cyc), 32'(H));
    check("b_data", 32'(sample_data), 32'd1);
    check("b_chan", 32'(sample_chan), 32'd0);

    // All requesting after reset: 0..15 then wrap to 0, one every H+2 cycles
    pulse_reset();
    din = 16'hA5C3;
    req = 16'hFFFF;
    sample_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_valid(cyc);
      check("c_chan", 32'(sample_chan), 32'(i % 16));
      check("c_period", 32'(cyc), (i == 0) ? 32'(H + 1) : 32'(H + 2));
    end
    drain();

    // Channel 10 select pattern
    dval = 16'($urandom);
    din = dval;
    req = 16'h0400;
    wait_valid(cyc);
    req = '0;
    check("d_sel", 32'({sel_0, sel_1, sel_2, sel_3}), 32'hA);
    check("d_data", 32'(sample_data), 32'(dval[10]));
    check("d_chan", 32'(sample_chan), 32'd10);
    drain();

    // Backpressure for 7 cycles in OFFER
    din = 16'h0020;
    sample_ready = 1'b0;
    req = 16'h0020;
    wait_valid(cyc);
    req = '0;
    check("e_data", 32'(sample_data), 32'd1);
    snap = {27'd0, sample_valid, sample_data, sample_chan[2:0]} ^
           {24'd0, sel_0, sel_1, sel_2, sel_3, 4'd0} ^ {sample_chan, 28'd0};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("e_stall",
            {27'd0, sample_valid, sample_data, sample_chan[2:0]} ^
            {24'd0, sel_0, sel_1, sel_2, sel_3, 4'd0} ^ {sample_chan, 28'd0},
            snap);
    end
    @(posedge clk);
    #1 sample_ready = 1'b1;
    @(negedge clk);
    check("e_valid_at_ready", 32'(sample_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("e_idle_after", 32'(busy), 32'd0);

    // Wrap: after 14, req 8001 gives 15 then 0
    req = 16'h4000;
    wait_valid(cyc);
    check("f_chan14", 32'(sample_chan), 32'd14);
    @(posedge clk);
    #1 req = 16'h8001;
    wait_valid(cyc);
    check("f_chan15", 32'(sample_chan), 32'd15);
    wait_valid(cyc);
    check("f_chan0", 32'(sample_chan), 32'd0);
    drain();

    // Reset during HOLD, then a fresh request to channel 2
    din = 16'h0004;
    req = 16'h0200;
    @(posedge clk);
    #1 req = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("g_reset_mid", all_outputs(), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    req = 16'h0004;
    wait_valid(cyc);
    check("g_latency", 32'(cyc), 32'(H + 1));
    check("g_chan", 32'(sample_chan), 32'd2);
    check("g_data", 32'(sample_data), 32'd1);
    drain();

    // Random soak against the model
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 599) == 0);
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = 16'd1 << $urandom_range(0, 15);
        2: req = 16'($urandom);
        default: req = 16'($urandom & $urandom);
      endcase
      sample_ready = ($urandom_range(0, 3) != 0);
      din = 16'($urandom);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    drain();
  endtask

  task automatic checkOutput();
    $display("%0d/%0d checks passed", passed, total);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

endmodule
